// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: DrawX/DrawY position, display enable, active-low syncs.
// Optional animation divider (anim_tick/anim_frame) is built only when VGA_ANIM_TICK_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned ANIM_DIV    = 6,
  parameter int unsigned ANIM_FRAMES = 4,
  localparam int unsigned CW         = 10,
  localparam int unsigned AW         = 3
) (
  input  logic          vga_clk,
  input  logic          reset,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          blank,
  output logic          hs,
  output logic          vs,
  output logic          frame_start,
  output logic          anim_tick,
  output logic [AW-1:0] anim_frame
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_VISIBLE + V_FP + V_SYNC);

  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          line_end;
  logic          next_blank;
  logic          next_hs;
  logic          next_vs;
  logic          next_frame_start;

  // Next raster position and the flags that will describe it once registered.
  always_comb begin
    line_end = (DrawX == H_LAST);
    next_x   = DrawX + CW'(1);
    next_y   = DrawY;
    if (line_end) begin
      next_x = '0;
      next_y = (DrawY == V_LAST) ? '0 : DrawY + CW'(1);
    end
    next_blank       = (next_x < H_VIS) && (next_y < V_VIS);
    next_hs          = !((next_x >= H_SYNC_BEG) && (next_x < H_SYNC_END));
    next_vs          = !((next_y >= V_SYNC_BEG) && (next_y < V_SYNC_END));
    next_frame_start = (next_x == '0) && (next_y == '0);
  end

  // Reset parks on the last pixel so the first edge after release lands on (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= next_x;
      DrawY       <= next_y;
      blank       <= next_blank;
      hs          <= next_hs;
      vs          <= next_vs;
      frame_start <= next_frame_start;
    end
  end

`ifdef VGA_ANIM_TICK_EN
  localparam logic [AW-1:0] DIV_LAST   = AW'(ANIM_DIV - 1);
  localparam logic [AW-1:0] FRAME_LAST = AW'(ANIM_FRAMES - 1);

  logic [AW-1:0] div_q;

  // Count frame_start pulses; the tick lands one cycle after the qualifying frame_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      anim_tick  <= 1'b0;
      anim_frame <= '0;
    end else begin
      anim_tick <= 1'b0;
      if (frame_start) begin
        if (div_q == DIV_LAST) begin
          div_q      <= '0;
          anim_tick  <= 1'b1;
          anim_frame <= (anim_frame == FRAME_LAST) ? '0 : anim_frame + AW'(1);
        end else begin
          div_q <= div_q + AW'(1);
        end
      end
    end
  end
`else
  // Divider absent: animation outputs are constant zero whatever the divider settings.
  localparam logic [AW-1:0] ANIM_TIE = AW'((ANIM_DIV + ANIM_FRAMES) * 0);

  assign anim_tick  = 1'b0;
  assign anim_frame = ANIM_TIE;
`endif

endmodule
